// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes LEGv8-style instruction requests (R, I, D, CB, B formats)
//            into 32-bit words and buffers them in an output FIFO of DEPTH
//            words. Invalid formats complete the handshake, are dropped and
//            raise a sticky error flag.
// Ports    :
//   iCLK    in   1          clock, rising edge active
//   iRSTn   in   1          asynchronous active-low reset
//   iVALID  in   1          request present
//   oREADY  out  1          request accepted when high (FIFO not full)
//   iFMT    in   3          0=R 1=I 2=D 3=CB 4=B, 5..7 invalid
//   iOPC    in   11         opcode, left-aligned
//   iRD     in   5          Rd/Rt field
//   iRN     in   5          Rn field
//   iRM     in   5          Rm field
//   iSHAMT  in   6          R-format shift amount
//   iIMM    in   26         immediate/offset, right-aligned
//   oINSTR  out  32         encoded word at FIFO head (0 when empty)
//   oVALID  out  1          FIFO not empty
//   iREADY  in   1          downstream accepts head word
//   oCOUNT  out  log2(D)+1  FIFO occupancy
//   oERR    out  1          sticky invalid-format flag
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                         iCLK,
  input  logic                         iRSTn,
  input  logic                         iVALID,
  output logic                         oREADY,
  input  logic [2:0]                   iFMT,
  input  logic [10:0]                  iOPC,
  input  logic [4:0]                   iRD,
  input  logic [4:0]                   iRN,
  input  logic [4:0]                   iRM,
  input  logic [5:0]                   iSHAMT,
  input  logic [25:0]                  iIMM,
  output logic [31:0]                  oINSTR,
  output logic                         oVALID,
  input  logic                         iREADY,
  output logic [$clog2(DEPTH):0]       oCOUNT,
  output logic                         oERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Pointer wrap relies on natural overflow, so DEPTH must be a power of two.
  generate
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("instr_encoder: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          err;

  logic [31:0]   enc_word;
  logic          fmt_ok;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;

  // --------------------------------------------------------------------------
  // Format encoder
  // --------------------------------------------------------------------------
  always_comb begin
    enc_word = '0;
    fmt_ok   = 1'b1;
    case (iFMT)
      3'd0:    enc_word = {iOPC, iRM, iSHAMT, iRN, iRD};
      3'd1:    enc_word = {iOPC[10:1], iIMM[11:0], iRN, iRD};
      3'd2:    enc_word = {iOPC, iIMM[8:0], 2'b00, iRN, iRD};
      3'd3:    enc_word = {iOPC[10:3], iIMM[18:0], iRD};
      3'd4:    enc_word = {iOPC[10:5], iIMM};
      default: fmt_ok   = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake. Ready depends only on occupancy, so a full FIFO refuses a
  // request even when the head is popped on the same edge.
  // --------------------------------------------------------------------------
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = iVALID && !full;
  assign push   = accept && fmt_ok;
  assign pop    = !empty && iREADY;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (accept && !fmt_ok) begin
        err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge iCLK) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oREADY = !full;
  assign oVALID = !empty;
  assign oINSTR = empty ? 32'h0 : mem[rd_ptr];
  assign oCOUNT = count;
  assign oERR   = err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder: table of single-word
//            encodings plus hand-written backpressure, invalid-format,
//            streaming and asynchronous-reset sequences against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          iCLK = 1'b0;
  logic          iRSTn;
  logic          iVALID;
  logic          oREADY;
  logic [2:0]    iFMT;
  logic [10:0]   iOPC;
  logic [4:0]    iRD;
  logic [4:0]    iRN;
  logic [4:0]    iRM;
  logic [5:0]    iSHAMT;
  logic [25:0]   iIMM;
  logic [31:0]   oINSTR;
  logic          oVALID;
  logic          iREADY;
  logic [CW-1:0] oCOUNT;
  logic          oERR;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iVALID (iVALID),
    .oREADY (oREADY),
    .iFMT   (iFMT),
    .iOPC   (iOPC),
    .iRD    (iRD),
    .iRN    (iRN),
    .iRM    (iRM),
    .iSHAMT (iSHAMT),
    .iIMM   (iIMM),
    .oINSTR (oINSTR),
    .oVALID (oVALID),
    .iREADY (iREADY),
    .oCOUNT (oCOUNT),
    .oERR   (oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0]  fmt;
    logic [10:0] opc;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        vec [8];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] q [$];
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [10:0] o, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] sh,
                         input logic [25:0] imm);
    iVALID = 1'b1;
    iFMT   = f;
    iOPC   = o;
    iRD    = rd;
    iRN    = rn;
    iRM    = rm;
    iSHAMT = sh;
    iIMM   = imm;
  endtask

  // B-format request; encoded word is 000101 followed by the 26-bit offset.
  task automatic set_b(input logic [25:0] imm);
    set_req(3'd4, 11'h0A0, 5'd0, 5'd0, 5'd0, 6'd0, imm);
  endtask

  function automatic logic [31:0] bw(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  // Called at a falling edge with inputs already driven: checks outputs
  // against the model, then advances one clock and updates the model.
  task automatic cyc(input string tag, input logic [31:0] w, output logic acc);
    logic rdy_e;
    logic push;
    logic pop;
    rdy_e = (q.size() < DEPTH);
    chk({tag, "_ready"}, 32'(oREADY), 32'(rdy_e));
    chk({tag, "_valid"}, 32'(oVALID), 32'(q.size() != 0));
    chk({tag, "_instr"}, oINSTR, (q.size() != 0) ? q[0] : 32'h0);
    chk({tag, "_count"}, 32'(oCOUNT), 32'(q.size()));
    chk({tag, "_err"},   32'(oERR),   32'(m_err));
    acc  = iVALID && rdy_e;
    push = acc && (iFMT <= 3'd4);
    pop  = (q.size() != 0) && iREADY;
    @(posedge iCLK);
    if (pop) begin
      void'(q.pop_front());
    end
    if (push) begin
      q.push_back(w);
    end
    if (acc && (iFMT > 3'd4)) begin
      m_err = 1'b1;
    end
    @(negedge iCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic got5;

    vec[0] = '{3'd0, 11'h458, 5'd1,  5'd2,  5'd3,  6'd0,  26'd0,        32'h8B030041};
    vec[1] = '{3'd2, 11'h7C2, 5'd9,  5'd22, 5'd0,  6'd0,  26'd64,       32'hF84402C9};
    vec[2] = '{3'd3, 11'h5A0, 5'd5,  5'd0,  5'd0,  6'd0,  26'd8,        32'hB4000105};
    vec[3] = '{3'd1, 11'h489, 5'd1,  5'd2,  5'd31, 6'd63, 26'h3FFF001,  32'h91000441};
    vec[4] = '{3'd4, 11'h0BF, 5'd31, 5'd31, 5'd31, 6'd63, 26'd3,        32'h14000003};
    vec[5] = '{3'd0, 11'h7FF, 5'd31, 5'd31, 5'd31, 6'd63, 26'd0,        32'hFFFFFFFF};
    vec[6] = '{3'd2, 11'h7C2, 5'd0,  5'd0,  5'd31, 6'd63, 26'h3FFFFFF,  32'hF85FF000};
    vec[7] = '{3'd3, 11'h7FF, 5'd0,  5'd31, 5'd31, 6'd63, 26'h3FFFFFF,  32'hFFFFFFE0};

    iRSTn  = 1'b1;
    iVALID = 1'b0;
    iREADY = 1'b0;
    iFMT   = 3'd0;
    iOPC   = '0;
    iRD    = '0;
    iRN    = '0;
    iRM    = '0;
    iSHAMT = '0;
    iIMM   = '0;
    m_err  = 1'b0;

    // Reset state
    #1 iRSTn = 1'b0;
    #1;
    chk("rst_valid", 32'(oVALID), 32'd0);
    chk("rst_instr", oINSTR,      32'h0);
    chk("rst_count", 32'(oCOUNT), 32'd0);
    chk("rst_err",   32'(oERR),   32'd0);
    chk("rst_ready", 32'(oREADY), 32'd1);
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);

    // Single-word encodings
    for (int i = 0; i < 8; i++) begin
      iREADY = 1'b0;
      set_req(vec[i].fmt, vec[i].opc, vec[i].rd, vec[i].rn, vec[i].rm, vec[i].shamt, vec[i].imm);
      cyc($sformatf("vec%0d_push", i), vec[i].exp, acc);
      iVALID = 1'b0;
      chk($sformatf("vec%0d_word", i), oINSTR, vec[i].exp);
      chk($sformatf("vec%0d_ovalid", i), 32'(oVALID), 32'd1);
      iREADY = 1'b1;
      cyc($sformatf("vec%0d_pop", i), 32'h0, acc);
      iREADY = 1'b0;
      chk($sformatf("vec%0d_empty", i), 32'(oVALID), 32'd0);
    end

    // Backpressure: five requests with downstream stalled
    iREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_b(26'(k + 1));
      cyc("bp_push", bw(26'(k + 1)), acc);
      chk($sformatf("bp_acc%0d", k), 32'(acc), 32'(k < 4));
    end
    chk("bp_full_count", 32'(oCOUNT), 32'd4);
    chk("bp_full_ready", 32'(oREADY), 32'd0);
    cyc("bp_hold", bw(26'd5), acc);
    chk("bp_hold_acc", 32'(acc), 32'd0);
    chk("bp_hold_head", oINSTR, bw(26'd1));
    iREADY = 1'b1;
    got5   = 1'b0;
    for (int n = 0; n < 12 && (!got5 || q.size() != 0); n++) begin
      cyc("bp_drain", bw(26'd5), acc);
      if (acc && !got5) begin
        got5   = 1'b1;
        iVALID = 1'b0;
      end
    end
    chk("bp_fifth_accepted", 32'(got5),   32'd1);
    chk("bp_drained",        32'(oCOUNT), 32'd0);

    // Invalid format with one word already buffered
    iREADY = 1'b0;
    set_b(26'h77);
    cyc("inv_pre", bw(26'h77), acc);
    set_req(3'd6, 11'h7FF, 5'd1, 5'd1, 5'd1, 6'd1, 26'h1);
    cyc("inv_req", 32'hDEADBEEF, acc);
    chk("inv_acc", 32'(acc), 32'd1);
    iVALID = 1'b0;
    chk("inv_count", 32'(oCOUNT), 32'd1);
    chk("inv_err",   32'(oERR),   32'd1);
    cyc("inv_idle", 32'h0, acc);
    set_b(26'h78);
    cyc("inv_post", bw(26'h78), acc);
    iVALID = 1'b0;
    iREADY = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc("inv_drain", 32'h0, acc);
    end
    chk("inv_err_held", 32'(oERR), 32'd1);

    // Streaming across pointer wrap
    iREADY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_b(26'(100 + k));
      cyc("stream", bw(26'(100 + k)), acc);
      chk($sformatf("stream_cnt%0d", k), 32'(oCOUNT), 32'd1);
    end
    iVALID = 1'b0;
    cyc("stream_tail", 32'h0, acc);

    // Asynchronous reset with three words buffered
    iREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_b(26'(200 + k));
      cyc("ar_fill", bw(26'(200 + k)), acc);
    end
    iVALID = 1'b0;
    chk("ar_pre_count", 32'(oCOUNT), 32'd3);
    #2 iRSTn = 1'b0;
    #1;
    chk("ar_valid", 32'(oVALID), 32'd0);
    chk("ar_count", 32'(oCOUNT), 32'd0);
    chk("ar_err",   32'(oERR),   32'd0);
    chk("ar_instr", oINSTR,      32'h0);
    chk("ar_ready", 32'(oREADY), 32'd1);
    q.delete();
    m_err = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);
    set_b(26'h55);
    cyc("ar_resume_push", bw(26'h55), acc);
    iVALID = 1'b0;
    cyc("ar_resume_hold", 32'h0, acc);
    iREADY = 1'b1;
    cyc("ar_resume_pop", 32'h0, acc);
    chk("ar_resume_empty", 32'(oVALID), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
